// File: rtl/regfile_mp_if.sv
// Bundle of read, write, busy-scoreboard and debug signals for regfile_mp.
// There is no valid/ready handshake: an enabled write or mark is always accepted at the next edge.
interface regfile_mp_if #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NREAD-1:0][AW-1:0]     ReadRegister;
  logic [NREAD-1:0][WIDTH-1:0]  ReadData;
  logic [NREAD-1:0]             ReadBusy;
  logic [NWRITE-1:0]            RegWrite;
  logic [NWRITE-1:0][AW-1:0]    WriteRegister;
  logic [NWRITE-1:0][WIDTH-1:0] WriteData;
  logic                         MarkBusy;
  logic [AW-1:0]                MarkRegister;
  logic [DEPTH-1:0][WIDTH-1:0]  reg_out;

  modport master (
    output ReadRegister, RegWrite, WriteRegister, WriteData, MarkBusy, MarkRegister,
    input  ReadData, ReadBusy, reg_out
  );

  modport slave (
    input  ReadRegister, RegWrite, WriteRegister, WriteData, MarkBusy, MarkRegister,
    output ReadData, ReadBusy, reg_out
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with zero register, write-to-read
// bypass, highest-port-wins write priority and a per-register busy scoreboard.
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            busy;

  // Zero register and out-of-range addresses are never stored, read or marked.
  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && (32'(a) != ZERO_REG);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest-index port wins.
      for (int j = 0; j < NWRITE; j++) begin
        if (bus.RegWrite[j] && valid_addr(bus.WriteRegister[j])) begin
          mem[bus.WriteRegister[j]]  <= bus.WriteData[j];
          busy[bus.WriteRegister[j]] <= 1'b0;
        end
      end
      // A mark issued with a write means a new producer, so the mark wins.
      if (bus.MarkBusy && valid_addr(bus.MarkRegister)) begin
        busy[bus.MarkRegister] <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.ReadData = '0;
    bus.ReadBusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (valid_addr(bus.ReadRegister[i])) begin
        bus.ReadData[i] = mem[bus.ReadRegister[i]];
        bus.ReadBusy[i] = busy[bus.ReadRegister[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWRITE; j++) begin
            if (bus.RegWrite[j] && (bus.WriteRegister[j] == bus.ReadRegister[i])) begin
              bus.ReadData[i] = bus.WriteData[j];
              bus.ReadBusy[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.reg_out = mem;
endmodule
